// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with 16x oversampling and a two-command decoder.
// 'R'/'r' pulse o_run_stop, 'C'/'c' pulse o_clear, each alongside o_rx_done.
module uart_cmd_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_run_stop,
  output logic       o_clear
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          rx_meta;
  logic          rx_s;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          is_run;
  logic          is_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CW'(1);
  end

  assign tick = (tick_cnt == CW'(DIV - 1));

  assign is_run   = (shift_reg == 8'h52) || (shift_reg == 8'h72);
  assign is_clear = (shift_reg == 8'h43) || (shift_reg == 8'h63);

  // START waits half a bit to land mid start bit; DATA/STOP then sample every
  // full bit. WAIT_IDLE swallows a held-low line after a framing error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_run_stop  <= 1'b0;
      o_clear     <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_run_stop  <= 1'b0;
      o_clear     <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            os_cnt  <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              os_cnt <= '0;
              state  <= rx_s ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt             <= '0;
              shift_reg[bit_idx] <= rx_s;
              bit_idx            <= bit_idx + 3'd1;
              if (bit_idx == 3'd7)
                state <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (rx_s) begin
                o_rx_data  <= shift_reg;
                o_rx_done  <= 1'b1;
                o_run_stop <= is_run;
                o_clear    <= is_clear;
                state      <= IDLE;
              end else begin
                o_frame_err <= 1'b1;
                state       <= WAIT_IDLE;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: command frames, back-to-back, glitch,
// framing error with break, reset mid-frame, and done-to-tick latency.
module tb_uart_cmd_rx;

  localparam int BAUD   = 9600;
  localparam int CLK_HZ = BAUD * 16 * 4;
  localparam int DIV    = 4;
  localparam int BIT_CLKS = 16 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_run_stop;
  logic       o_clear;

  int n_assert = 0;
  int n_fail   = 0;

  int done_n = 0, err_n = 0, run_n = 0, clr_n = 0;
  int late_err = 0, wide_err = 0, cmd_err = 0, both_err = 0;
  logic p_done = 0, p_err = 0, p_run = 0, p_clr = 0;
  int tb_cnt;
  int d0, e0, r0, c0;

  uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .o_rx_data(o_rx_data),
    .o_rx_done(o_rx_done),
    .o_frame_err(o_frame_err),
    .o_run_stop(o_run_stop),
    .o_clear(o_clear)
  );

  always #5 clk = ~clk;

  // Independent model of the oversample tick phase
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (o_rx_done)   begin done_n++; if (tb_cnt != 0) late_err++; end
      if (o_frame_err) begin err_n++;  if (tb_cnt != 0) late_err++; end
      if (o_run_stop) run_n++;
      if (o_clear)    clr_n++;
      if ((o_run_stop || o_clear) && !o_rx_done) cmd_err++;
      if (o_run_stop && o_clear) both_err++;
      if ((o_rx_done && p_done) || (o_frame_err && p_err) ||
          (o_run_stop && p_run) || (o_clear && p_clr)) wide_err++;
    end
    p_done = o_rx_done;
    p_err  = o_frame_err;
    p_run  = o_run_stop;
    p_clr  = o_clear;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
    hold(stop_bit, BIT_CLKS);
  endtask

  task automatic snap();
    d0 = done_n; e0 = err_n; r0 = run_n; c0 = clr_n;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", o_rx_data, 8'h00);
    check("rst_pulses", {o_rx_done, o_frame_err, o_run_stop, o_clear}, 4'b0000);
    reset = 1'b0;
    hold(1'b1, 2 * BIT_CLKS);

    // 'R' -> run/stop
    snap();
    send_frame(8'h52, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("r_data", o_rx_data, 8'h52);
    check("r_done", done_n - d0, 1);
    check("r_run", run_n - r0, 1);
    check("r_clear", clr_n - c0, 0);

    // 'c' then 'A' back-to-back
    snap();
    send_frame(8'h63, 1'b1);
    check("c_data", o_rx_data, 8'h63);
    check("c_clear", clr_n - c0, 1);
    send_frame(8'h41, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("a_data", o_rx_data, 8'h41);
    check("ca_done", done_n - d0, 2);
    check("ca_clear", clr_n - c0, 1);
    check("ca_run", run_n - r0, 0);

    // Start glitch of 3 ticks
    snap();
    hold(1'b0, 3 * DIV);
    hold(1'b1, 2 * BIT_CLKS);
    check("gl_pulses", (done_n - d0) + (err_n - e0), 0);
    check("gl_data", o_rx_data, 8'h41);

    // 'r' with low stop bit, break for two frames, then 'C'
    snap();
    send_frame(8'h72, 1'b0);
    hold(1'b0, 20 * BIT_CLKS);
    hold(1'b1, 2 * BIT_CLKS);
    check("fe_err", err_n - e0, 1);
    check("fe_done", done_n - d0, 0);
    check("fe_run", run_n - r0, 0);
    check("fe_data", o_rx_data, 8'h41);
    send_frame(8'h43, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("C_data", o_rx_data, 8'h43);
    check("C_done", done_n - d0, 1);
    check("C_clear", clr_n - c0, 1);
    check("C_err", err_n - e0, 1);

    // Reset during bit 4 of 0x52
    snap();
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS / 2);
    reset = 1'b1;
    #1;
    check("rst_mid_data", o_rx_data, 8'h00);
    check("rst_mid_pulses", {o_rx_done, o_frame_err, o_run_stop, o_clear}, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b1, 3 * BIT_CLKS);
    check("abort_pulses", (done_n - d0) + (err_n - e0), 0);
    check("abort_data", o_rx_data, 8'h00);
    send_frame(8'h52, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("R2_data", o_rx_data, 8'h52);
    check("R2_done", done_n - d0, 1);
    check("R2_run", run_n - r0, 1);
    check("R2_clear", clr_n - c0, 0);

    // Whole-run pulse properties
    check("done_total", done_n, 5);
    check("err_total", err_n, 1);
    check("tick_latency", late_err, 0);
    check("pulse_width", wide_err, 0);
    check("cmd_without_done", cmd_err, 0);
    check("run_and_clear", both_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter DIV, default CLK_HZ/(BAUD*16) (integer division, 651 at defaults), clocks per oversample tick.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  UART serial line, idle high, 8N1 frame, LSB first, asynchronous to clk.
REQ-007 o_rx_data  output  8  last correctly framed byte.
REQ-008 o_rx_done  output  1  one-clk pulse when a correctly framed byte is latched.
REQ-009 o_frame_err  output  1  one-clk pulse when the stop bit samples low.
REQ-010 o_run_stop  output  1  one-clk pulse on receipt of 'R' (0x52) or 'r' (0x72); pulse width matches a debounced run/stop button edge.
REQ-011 o_clear  output  1  one-clk pulse on receipt of 'C' (0x43) or 'c' (0x63); pulse width matches a debounced clear button edge.

Function
REQ-012 rx passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value only.
REQ-013 Free-running tick counter counts 0..DIV-1 and wraps; a tick is a one-clk strobe at count DIV-1.
REQ-014 States: IDLE, START, DATA, STOP, WAIT_IDLE; FSM advances only on ticks, except for the IDLE exit.
REQ-015 IDLE: on synchronized rx low, go to START, clear the oversample count (4 bits) and the bit index (3 bits).
REQ-016 START: on the 8th tick, if rx is low, go to DATA with the oversample count cleared; if rx is high, treat it as a glitch and return to IDLE with no output.
REQ-017 DATA: on every 16th tick, shift rx into bit[index] (LSB first) and increment the index; after bit 7, go to STOP.
REQ-018 STOP: on the 16th tick, sample rx. If high, load the shift register into o_rx_data, pulse o_rx_done, and go to IDLE. If low, pulse o_frame_err, leave o_rx_data unchanged, and go to WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until synchronized rx is high, then go to IDLE; a held-low line (break) produces no further outputs.
REQ-020 o_run_stop and o_clear are asserted in the same clk as o_rx_done, and only when o_rx_done is asserted; other byte values produce only o_rx_done.
REQ-021 o_run_stop and o_clear are never asserted together; none of the pulse outputs is ever wider than one clk.
REQ-022 Latency: o_rx_done rises exactly 1 clk after the stop-bit sampling tick.
REQ-023 Back-to-back frames, with the next start edge in the same clk the FSM returns to IDLE, are received without loss.
REQ-024 o_rx_data holds its value until the next good frame.

Reset
REQ-025 On reset assertion, all outputs go to 0 immediately: o_rx_data = 0x00 and all pulses = 0.
REQ-026 On reset assertion, the FSM goes to IDLE, the tick and oversample counters go to 0, and the synchronizer flops go to 1.
REQ-027 Reset mid-frame aborts the frame with no pulses; after release, the receiver waits for a fresh start edge.

Verification
REQ-028 Send 0x52 at 9600 baud -> o_rx_data=0x52; o_rx_done and o_run_stop pulse once for 1 clk together; o_clear stays 0.
REQ-029 Send 0x63 then 0x41 back-to-back -> first frame: o_clear pulse; second frame: o_rx_data=0x41, o_rx_done only, no command pulse.
REQ-030 rx low pulse of 3 oversample ticks, then high -> no pulses, FSM back in IDLE, o_rx_data unchanged.
REQ-031 Frame 0x72 with stop bit low -> o_frame_err pulse, no o_rx_done, no o_run_stop, o_rx_data keeps its previous value; rx held low for 2 frames then high, followed by 0x43 -> only the o_clear/o_rx_done pulse.
REQ-032 Assert reset during bit 4 of 0x52, release, then send 0x52 -> no pulse for the aborted frame; the second frame decodes normally.
REQ-033 Check o_rx_done timing against the stop-bit sampling tick: exactly 1 clk after it (REQ-022).
